// File: rtl/prism_input_filter.sv
// PRISM input filter: per-channel two-flop synchronizer plus a counter-based
// debouncer, with edge pulses, sticky edge flags and a level edge interrupt.
// The register map packs per-channel fields into 8-bit slots, so WIDTH and
// CNT_W must both stay at or below 8.

// One debounced channel: synchronizer, stability counter, edge pulses.
module prism_input_filter_lane #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw,
    input  logic [CNT_W-1:0] thr_m1,
    output logic             filt,
    output logic             rise,
    output logic             fall
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             hit;

    assign differ = (s2 != filt);
    // A lowered threshold can leave cnt above thr_m1; >= still fires then.
    assign hit    = (cnt >= thr_m1);

    // Synchronize, then count disagreeing cycles until the threshold is met.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (!differ) begin
                cnt <= '0;
            end else if (hit) begin
                filt <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module prism_input_filter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_raw,
    input  logic [5:0]       address,
    input  logic [31:0]      data_in,
    input  logic [1:0]       data_write_n,
    output logic [31:0]      data_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             edge_irq
);

    localparam logic [5:0] ADDR_CTRL   = 6'h30;
    localparam logic [5:0] ADDR_STATUS = 6'h34;

    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] thr_m1;
    logic [WIDTH-1:0] irq_en_rise;
    logic [WIDTH-1:0] irq_en_fall;
    logic [WIDTH-1:0] rise_flg;
    logic [WIDTH-1:0] fall_flg;
    logic             wr;
    logic             wr_ctrl;
    logic             wr_stat;
    logic [WIDTH-1:0] clr_rise;
    logic [WIDTH-1:0] clr_fall;

    assign wr       = (data_write_n == 2'b10);
    assign wr_ctrl  = wr && (address == ADDR_CTRL);
    assign wr_stat  = wr && (address == ADDR_STATUS);
    assign clr_rise = wr_stat ? data_in[0 +: WIDTH] : '0;
    assign clr_fall = wr_stat ? data_in[8 +: WIDTH] : '0;

    // Threshold 0 behaves like 1; lanes compare cnt against N-1.
    assign thr_m1 = (thr == '0) ? '0 : thr - 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            prism_input_filter_lane #(.CNT_W(CNT_W)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .raw    (in_raw[i]),
                .thr_m1 (thr_m1),
                .filt   (filt_out[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
            );
        end
    endgenerate

    // CTRL register: shared threshold and interrupt enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr         <= '0;
            irq_en_rise <= '0;
            irq_en_fall <= '0;
        end else if (wr_ctrl) begin
            thr         <= data_in[CNT_W-1:0];
            irq_en_rise <= data_in[8 +: WIDTH];
            irq_en_fall <= data_in[16 +: WIDTH];
        end
    end

    // Sticky edge flags: a pulse in the same cycle as a W1C wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_flg <= '0;
            fall_flg <= '0;
        end else begin
            rise_flg <= (rise_flg & ~clr_rise) | rise;
            fall_flg <= (fall_flg & ~clr_fall) | fall;
        end
    end

    // Combinational, side-effect-free register read mux.
    always_comb begin
        data_out = '0;
        case (address)
            ADDR_CTRL: begin
                data_out[CNT_W-1:0]   = thr;
                data_out[8 +: WIDTH]  = irq_en_rise;
                data_out[16 +: WIDTH] = irq_en_fall;
            end
            ADDR_STATUS: begin
                data_out[0 +: WIDTH]  = rise_flg;
                data_out[8 +: WIDTH]  = fall_flg;
                data_out[16 +: WIDTH] = filt_out;
            end
            default: data_out = '0;
        endcase
    end

    assign edge_irq = |((rise_flg & irq_en_rise) | (fall_flg & irq_en_fall));

endmodule

// File: tb/tb_prism_input_filter.sv
// Self-checking bench for prism_input_filter: register table, directed corner
// sequences and a randomized run against a run-length reference model.
module tb_prism_input_filter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_raw;
    logic [5:0]       address;
    logic [31:0]      data_in;
    logic [1:0]       data_write_n;
    logic [31:0]      data_out;
    logic [WIDTH-1:0] filt_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             edge_irq;

    int checks = 0;
    int errors = 0;

    prism_input_filter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_raw       (in_raw),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_out     (data_out),
        .filt_out     (filt_out),
        .rise         (rise),
        .fall         (fall),
        .edge_irq     (edge_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: hist holds the synchronized sample seen at each edge,
    // a channel flips once N consecutive samples disagree with its level.
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_filt, m_rise, m_fall, m_rf, m_ff, m_enr, m_enf;
    logic [3:0]       m_thr;

    function automatic logic [31:0] mread(logic [5:0] a);
        if (a == 6'h30) return {8'h0, m_enf, m_enr, 4'h0, m_thr};
        if (a == 6'h34) return {8'h0, m_filt, m_ff, m_rf};
        return 32'h0;
    endfunction

    task automatic model_edge();
        logic [WIDTH-1:0] clr_r, clr_f, nf, nr, nfl;
        int n, run;
        logic w;
        if (rst) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            m_filt = '0; m_rise = '0; m_fall = '0;
            m_rf = '0; m_ff = '0; m_enr = '0; m_enf = '0; m_thr = '0;
        end else begin
            w = (data_write_n == 2'b10);
            clr_r = (w && address == 6'h34) ? data_in[7:0]  : '0;
            clr_f = (w && address == 6'h34) ? data_in[15:8] : '0;
            m_rf = (m_rf & ~clr_r) | m_rise;
            m_ff = (m_ff & ~clr_f) | m_fall;
            n = (m_thr == 0) ? 1 : int'(m_thr);
            nf = m_filt; nr = '0; nfl = '0;
            for (int ch = 0; ch < WIDTH; ch++) begin
                run = 0;
                for (int idx = hist.size() - 2; idx >= 0 && run < 16; idx--) begin
                    if (hist[idx][ch] != m_filt[ch]) run++;
                    else break;
                end
                if (run >= n) begin
                    nf[ch] = ~m_filt[ch];
                    if (nf[ch]) nr[ch] = 1'b1;
                    else        nfl[ch] = 1'b1;
                end
            end
            m_filt = nf; m_rise = nr; m_fall = nfl;
            if (w && address == 6'h30) begin
                m_thr = data_in[3:0];
                m_enr = data_in[15:8];
                m_enf = data_in[23:16];
            end
            hist.push_back(in_raw);
            if (hist.size() > 40) void'(hist.pop_front());
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("filt_out", 32'(filt_out), 32'(m_filt));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("edge_irq", 32'(edge_irq), 32'(|((m_rf & m_enr) | (m_ff & m_enf))));
        chk("data_out", data_out, mread(address));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wr_reg(logic [5:0] a, logic [31:0] d);
        address = a; data_in = d; data_write_n = 2'b10;
        step();
        data_write_n = 2'b11;
    endtask

    task automatic rd(string nm, logic [5:0] a, logic [31:0] exp);
        address = a;
        #1;
        chk(nm, data_out, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  wn;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];
    logic saw;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b10, 6'h30, 32'hFFFF_FFFF, 6'h30, 32'h00FF_FF0F};
        vecs[1] = '{2'b01, 6'h30, 32'h0000_0000, 6'h30, 32'h00FF_FF0F};
        vecs[2] = '{2'b00, 6'h30, 32'h0000_0000, 6'h30, 32'h00FF_FF0F};
        vecs[3] = '{2'b11, 6'h30, 32'h0000_0000, 6'h30, 32'h00FF_FF0F};
        vecs[4] = '{2'b10, 6'h30, 32'h1234_5678, 6'h30, 32'h0034_5608};
        vecs[5] = '{2'b10, 6'h34, 32'hFFFF_FFFF, 6'h34, 32'h0000_0000};
        vecs[6] = '{2'b10, 6'h38, 32'hFFFF_FFFF, 6'h38, 32'h0000_0000};
        vecs[7] = '{2'b10, 6'h31, 32'h0000_0000, 6'h30, 32'h0034_5608};
        vecs[8] = '{2'b10, 6'h00, 32'hFFFF_FFFF, 6'h00, 32'h0000_0000};
        vecs[9] = '{2'b10, 6'h30, 32'h0000_0000, 6'h30, 32'h0000_0000};

        rst = 1'b1; in_raw = '0; address = 6'h30; data_in = '0; data_write_n = 2'b11;
        do_reset();
        chk("reset_filt", 32'(filt_out), 32'h0);
        chk("reset_irq", 32'(edge_irq), 32'h0);
        rd("reset_ctrl", 6'h30, 32'h0);
        rd("reset_status", 6'h34, 32'h0);

        // Register table.
        foreach (vecs[k]) begin
            address = vecs[k].waddr; data_in = vecs[k].wdata; data_write_n = vecs[k].wn;
            step();
            data_write_n = 2'b11;
            rd($sformatf("reg_vec%0d", k), vecs[k].raddr, vecs[k].exp);
        end

        // Short glitch under THR=5 is swallowed.
        do_reset();
        wr_reg(6'h30, 32'h5);
        saw = 1'b0;
        in_raw = 8'h08;
        repeat (4) begin step(); saw |= rise[3]; end
        in_raw = 8'h00;
        repeat (6) begin step(); saw |= rise[3]; end
        chk("glitch_filt3", 32'(filt_out[3]), 32'h0);
        chk("glitch_norise", 32'(saw), 32'h0);
        rd("glitch_status", 6'h34, 32'h0);

        // Held input under THR=5: flips after edge k+6, then falls.
        in_raw = 8'h08;
        repeat (6) step();
        chk("hold_filt3_early", 32'(filt_out[3]), 32'h0);
        step();
        chk("hold_filt3", 32'(filt_out[3]), 32'h1);
        chk("hold_rise3", 32'(rise), 32'h08);
        in_raw = 8'h00;
        repeat (6) step();
        chk("hold_nofall_early", 32'(fall), 32'h0);
        step();
        chk("hold_fall3", 32'(fall), 32'h08);
        address = 6'h34;
        step();
        chk("hold_status", data_out, 32'h0000_0808);

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < WIDTH; b++)
                if ($urandom_range(0, 9) == 0) in_raw[b] = ~in_raw[b];
            rst = ($urandom_range(0, 599) == 0);
            data_write_n = 2'b11;
            case ($urandom_range(0, 19))
                0: begin
                    address = 6'h30; data_write_n = 2'b10; data_in = $urandom;
                    data_in[3:0] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
                end
                1, 2: begin address = 6'h34; data_write_n = 2'b10; data_in = $urandom; end
                3: begin address = 6'($urandom); data_write_n = 2'($urandom); data_in = $urandom; end
                4, 5, 6: address = 6'($urandom);
                7, 8, 9: address = 6'h30;
                default: address = 6'h34;
            endcase
            step();
        end
        rst = 1'b0; data_write_n = 2'b11;

        // THR=0: two-flop sync then immediate flip.
        in_raw = '0;
        do_reset();
        in_raw = 8'h01;
        step();
        step();
        chk("thr0_filt_early", 32'(filt_out[0]), 32'h0);
        step();
        chk("thr0_filt", 32'(filt_out[0]), 32'h1);
        chk("thr0_rise", 32'(rise), 32'h01);
        address = 6'h34;
        step();
        chk("thr0_rise_clear", 32'(rise), 32'h0);
        chk("thr0_status", data_out, 32'h0001_0001);

        // Interrupt enable, W1C, and W1C coincident with a new rise.
        wr_reg(6'h30, 32'h0000_0100);
        chk("irq_set", 32'(edge_irq), 32'h1);
        wr_reg(6'h34, 32'h1);
        chk("irq_cleared", 32'(edge_irq), 32'h0);
        in_raw = 8'h00;
        repeat (4) step();
        in_raw = 8'h01;
        step();
        step();
        step();
        chk("w1c_rise_now", 32'(rise), 32'h01);
        wr_reg(6'h34, 32'h1);
        chk("w1c_coincident_irq", 32'(edge_irq), 32'h1);
        rd("w1c_coincident_flag", 6'h34, 32'h0001_0101);

        // Threshold lowered mid-count flips on the following edge.
        in_raw = 8'h00;
        do_reset();
        wr_reg(6'h30, 32'hF);
        in_raw = 8'h02;
        repeat (9) step();
        wr_reg(6'h30, 32'h4);
        chk("thr_drop_before", 32'(filt_out[1]), 32'h0);
        step();
        chk("thr_drop_filt", 32'(filt_out[1]), 32'h1);
        chk("thr_drop_rise", 32'(rise), 32'h02);

        // Reset mid-count discards the count; held-high input rises 2+N after release.
        wr_reg(6'h30, 32'hF);
        in_raw = 8'h01;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("rst_filt", 32'(filt_out), 32'h0);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_fall", 32'(fall), 32'h0);
        chk("rst_irq", 32'(edge_irq), 32'h0);
        rd("rst_ctrl", 6'h30, 32'h0);
        rst = 1'b0;
        step();
        step();
        chk("release_norise", 32'(rise), 32'h0);
        step();
        chk("release_rise", 32'(rise), 32'h01);
        chk("release_filt", 32'(filt_out), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
